// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with a one-cycle ready strobe.
// Optional DIV_EARLY_EXIT_EN: finish at once when |dividend| < |divisor|.
module div_iter #(
  parameter int unsigned DIV_W = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_start,
  input  logic                 signed_div,
  input  logic [DIV_W-1:0]     opdata1,
  input  logic [DIV_W-1:0]     opdata2,
  input  logic                 annul,
  output logic                 div_ready,
  output logic [2*DIV_W-1:0]   result
);

  typedef enum logic [1:0] {IDLE, BYZERO, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DIV_W-1:0]   dvd;
  logic [DIV_W-1:0]   dvs;
  logic [DIV_W-1:0]   rem;
  logic [DIV_W-1:0]   quo;
  logic               neg_q;
  logic               neg_r;

  logic [DIV_W-1:0]   abs1;
  logic [DIV_W-1:0]   abs2;
  logic [DIV_W:0]     rem_sh;
  logic [DIV_W-1:0]   rem_nx;
  logic [DIV_W-1:0]   quo_nx;
  logic [DIV_W-1:0]   q_fin;
  logic [DIV_W-1:0]   r_fin;

  always_comb begin
    abs1   = (signed_div && opdata1[DIV_W-1]) ? -opdata1 : opdata1;
    abs2   = (signed_div && opdata2[DIV_W-1]) ? -opdata2 : opdata2;
    // Partial remainder stays below the divisor, so one extra bit holds the shift.
    rem_sh = {rem, dvd[DIV_W-1]};
    if (rem_sh >= {1'b0, dvs}) begin
      rem_nx = rem_sh[DIV_W-1:0] - dvs;
      quo_nx = {quo[DIV_W-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[DIV_W-1:0];
      quo_nx = {quo[DIV_W-2:0], 1'b0};
    end
    q_fin = neg_q ? -quo_nx : quo_nx;
    r_fin = neg_r ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_ready <= 1'b0;
      result    <= '0;
    end else begin
      div_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (!annul && div_start) begin
            dvd   <= abs1;
            dvs   <= abs2;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            neg_q <= signed_div & (opdata1[DIV_W-1] ^ opdata2[DIV_W-1]);
            neg_r <= signed_div & opdata1[DIV_W-1];
            if (opdata2 == '0) begin
              state <= BYZERO;
`ifdef DIV_EARLY_EXIT_EN
            end else if (abs1 < abs2) begin
              state     <= DONE;
              div_ready <= 1'b1;
              result    <= {opdata1, {DIV_W{1'b0}}};
`endif
            end else begin
              state <= BUSY;
            end
          end
        end
        BYZERO: begin
          if (annul || !div_start) begin
            state <= IDLE;
          end else begin
            state     <= DONE;
            div_ready <= 1'b1;
            result    <= '0;
          end
        end
        BUSY: begin
          if (annul || !div_start) begin
            state <= IDLE;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            dvd <= dvd << 1;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state     <= DONE;
              div_ready <= 1'b1;
              result    <= {r_fin, q_fin};
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: 64-bit arithmetic reference model, per-cycle compare.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        annul = 1'b0;
  logic        div_ready;
  logic [63:0] result;

  int n_pass = 0;
  int n_total = 0;

  logic        exp_ready = 1'b0;
  logic [63:0] exp_result = '0;

  div_iter #(.DIV_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .div_ready  (div_ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Outputs must match the model on every cycle.
  always @(negedge clk) begin
    n_total++;
    if (div_ready === exp_ready && result === exp_result) n_pass++;
    else $display("FAIL cycle_check t=%0t ready got %b req %b result got %h req %h",
                  $time, div_ready, exp_ready, result, exp_result);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s got %h required %h", name, got, req);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_total++;
    if (got == req) n_pass++;
    else $display("FAIL %s got %0d required %0d", name, got, req);
  endtask

  function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] val, output int lat);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      val = '0;
      lat = 2;
      return;
    end
    sa = sg ? {{32{a[31]}}, a} : {32'd0, a};
    sb = sg ? {{32{b[31]}}, b} : {32'd0, b};
    q = sa / sb;
    r = sa % sb;
    val = {r[31:0], q[31:0]};
    lat = 33;
`ifdef DIV_EARLY_EXIT_EN
    if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) lat = 1;
`endif
  endfunction

  // Entered just after a rising edge with the DUT idle; that cycle is cycle 0.
  task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, input bit by_annul,
                        output logic [63:0] got, output int rdy_cyc);
    logic [63:0] val;
    int lat;
    model(sg, a, b, val, lat);
    signed_div = sg;
    opdata1    = a;
    opdata2    = b;
    annul      = 1'b0;
    div_start  = 1'b1;
    got        = result;
    rdy_cyc    = -1;
    if (abort_at > 0 && abort_at < lat) begin
      for (int k = 1; k <= abort_at; k++) begin
        @(posedge clk); #1;
        if (div_ready && rdy_cyc < 0) rdy_cyc = k;
        opdata1 = $urandom;
        opdata2 = $urandom;
        if (k == abort_at) begin
          if (by_annul) annul = 1'b1;
          else div_start = 1'b0;
        end
      end
      @(posedge clk); #1;
      if (div_ready && rdy_cyc < 0) rdy_cyc = abort_at + 1;
      annul     = 1'b0;
      div_start = 1'b0;
      got       = result;
    end else begin
      for (int k = 1; k <= lat + 1; k++) begin
        @(posedge clk); #1;
        if (div_ready && rdy_cyc < 0) begin
          rdy_cyc = k;
          got     = result;
        end
        // In-flight operands must come from the latched copies.
        opdata1   = $urandom;
        opdata2   = $urandom;
        exp_ready = (k == lat);
        if (k == lat) begin
          exp_result = val;
          div_start  = 1'b0;
        end
      end
    end
  endtask

  logic [63:0] got, mval;
  int          rc, mlat;
  int          exp_lat_small;
  bit          seen;

  initial begin
`ifdef DIV_EARLY_EXIT_EN
    exp_lat_small = 1;
`else
    exp_lat_small = 33;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(div_ready), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    model(1'b0, 32'd100, 32'd7, mval, mlat);
    check("model_100_7", mval, 64'h00000002_0000000E);
    model(1'b1, 32'h80000000, 32'hFFFFFFFF, mval, mlat);
    check("model_minint", mval, 64'h00000000_80000000);

    do_div(1'b0, 32'd100, 32'd7, 0, 1'b0, got, rc);
    check("divu_100_7", got, 64'h00000002_0000000E);
    check_int("divu_100_7_lat", rc, 33);

    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, 1'b0, got, rc);
    check("div_m7_2", got, 64'hFFFFFFFF_FFFFFFFD);

    do_div(1'b0, 32'hFFFFFFFF, 32'd1, 0, 1'b0, got, rc);
    check("divu_max_1", got, 64'h00000000_FFFFFFFF);

    do_div(1'b1, 32'd5, 32'd0, 0, 1'b0, got, rc);
    check("div_by_zero", got, 64'd0);
    check_int("div_by_zero_lat", rc, 2);

    do_div(1'b0, 32'd20, 32'd3, 0, 1'b0, got, rc);
    check("divu_20_3", got, 64'h00000002_00000006);
    check_int("divu_20_3_lat", rc, 33);

    do_div(1'b0, 32'd100, 32'd7, 10, 1'b1, got, rc);
    check_int("annul_no_ready", rc, -1);
    check("annul_hold", got, 64'h00000002_00000006);

    do_div(1'b0, 32'd100, 32'd7, 0, 1'b0, got, rc);
    check("restart_100_7", got, 64'h00000002_0000000E);
    check_int("restart_lat", rc, 33);

    do_div(1'b1, 32'd9, 32'd0, 1, 1'b0, got, rc);
    check_int("byzero_drop_no_ready", rc, -1);

    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, got, rc);
    check("div_minint", got, 64'h00000000_80000000);

    do_div(1'b1, 32'd3, 32'd10, 0, 1'b0, got, rc);
    check("div_3_10", got, 64'h00000003_00000000);
    check_int("div_3_10_lat", rc, exp_lat_small);

    // Asynchronous reset in cycle 15 of a divide.
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    div_start  = 1'b1;
    seen       = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (div_ready) seen = 1'b1;
    end
    rst        = 1'b1;
    exp_ready  = 1'b0;
    exp_result = '0;
    #1;
    check("async_rst_ready", 64'(div_ready), 64'd0);
    check("async_rst_result", result, 64'd0);
    div_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (div_ready) seen = 1'b1;
    end
    check("no_spurious_ready", 64'(seen), 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      bit          sg;
      int          ab;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       a = $urandom_range(0, 20);
        1:       a = 32'h80000000;
        default: a = $urandom;
      endcase
      model(sg, a, b, mval, mlat);
      ab = ($urandom_range(0, 5) == 0 && mlat > 1) ? $urandom_range(1, mlat - 1) : 0;
      do_div(sg, a, b, ab, 1'($urandom_range(0, 1)), got, rc);
      if (ab == 0) begin
        check("rand_result", got, mval);
        check_int("rand_lat", rc, mlat);
      end else begin
        check_int("rand_abort_no_ready", rc, -1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
